// File: rtl/add_acc_stage_if.sv
// rtl/add_acc_stage_if.sv - operand and result stream bundle for add_acc_stage
interface add_acc_stage_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] din_data;
  logic                  din_vld;
  logic                  din_rd;
  logic [DATA_WIDTH-1:0] dout_data;
  logic                  dout_ovf;
  logic                  dout_vld;
  logic                  dout_rd;

  // Producer of operands and consumer of results
  modport master (
    output din_data, din_vld, dout_rd,
    input  din_rd, dout_data, dout_ovf, dout_vld
  );

  // The accumulator stage itself
  modport slave (
    input  din_data, din_vld, dout_rd,
    output din_rd, dout_data, dout_ovf, dout_vld
  );
endinterface

// File: rtl/add_acc_stage.sv
// rtl/add_acc_stage.sv - block accumulator (optional ADD_ACC_SATURATE_EN clamps on carry-out)
module add_acc_stage #(
  parameter int DATA_WIDTH = 4,
  parameter int BLOCK_LEN  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  add_acc_stage_if.slave  bus
);

  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    ST_ACC,
    ST_EMIT
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  ovf_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic                  res_ovf_q;

  logic                  din_rd_c;
  logic                  dout_vld_c;
  logic                  accept;
  logic                  xfer;
  logic                  last;
  logic [DATA_WIDTH-1:0] sum;
  logic                  co;
  logic [DATA_WIDTH-1:0] acc_nxt;
  logic                  ovf_nxt;

  assign last = (cnt_q == LAST_CNT);

  // Ripple-carry chain: acc + din + 0, one full adder per bit
  always_comb begin
    logic c;
    c   = 1'b0;
    sum = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      sum[i] = acc_q[i] ^ bus.din_data[i] ^ c;
      c      = (acc_q[i] & bus.din_data[i]) | (c & (acc_q[i] ^ bus.din_data[i]));
    end
    co = c;
  end

  // Accumulator update: wrap by default, clamp to all-ones on carry when saturating
  always_comb begin
`ifdef ADD_ACC_SATURATE_EN
    acc_nxt = co ? {DATA_WIDTH{1'b1}} : sum;
`else
    acc_nxt = sum;
`endif
    ovf_nxt = ovf_q | co;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; clr overrides everything
  always_comb begin
    state_d    = state_q;
    din_rd_c   = 1'b0;
    dout_vld_c = 1'b0;
    accept     = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      ST_ACC: begin
        din_rd_c = rst_n & ~clr;
        accept   = bus.din_vld & din_rd_c;
        if (accept && last) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        dout_vld_c = 1'b1;
        xfer       = bus.dout_rd & ~clr;
        if (xfer) begin
          state_d = ST_ACC;
        end
      end
      default: state_d = ST_ACC;
    endcase
    if (clr) begin
      state_d = ST_ACC;
    end
  end

  // Running sum, sticky overflow, sample count and the held block result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      res_data_q <= '0;
      res_ovf_q  <= 1'b0;
    end else if (clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      acc_q <= acc_nxt;
      ovf_q <= ovf_nxt;
      if (last) begin
        cnt_q      <= '0;
        res_data_q <= acc_nxt;
        res_ovf_q  <= ovf_nxt;
      end else begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end else if (xfer) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  assign bus.din_rd    = din_rd_c;
  assign bus.dout_vld  = dout_vld_c;
  assign bus.dout_data = res_data_q;
  assign bus.dout_ovf  = res_ovf_q;

endmodule

// File: tb/tb_add_acc_stage.sv
// tb/tb_add_acc_stage.sv - self-checking bench for add_acc_stage
module tb_add_acc_stage;
  localparam int DW = 4;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  add_acc_stage_if #(.DATA_WIDTH(DW)) bus ();

  add_acc_stage #(.DATA_WIDTH(DW), .BLOCK_LEN(BL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       o_acc, o_xfer, o_vld, o_drd, o_ovf;
  logic [3:0] o_data;

  typedef struct {
    logic [15:0] s;
    logic [3:0]  exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Block result from the plain sum of its samples
  function automatic logic [4:0] model(input int total);
    logic [31:0] t;
    t = total;
`ifdef ADD_ACC_SATURATE_EN
    return (total > 15) ? 5'h1F : {1'b0, t[3:0]};
`else
    return {(total > 15), t[3:0]};
`endif
  endfunction

  // One clock: drive at negedge, observe handshake just before the edge
  task automatic cyc(input logic vld, input logic [3:0] d, input logic rd, input logic c);
    @(negedge clk);
    bus.din_vld  = vld;
    bus.din_data = d;
    bus.dout_rd  = rd;
    clr          = c;
    #1;
    o_drd  = bus.din_rd;
    o_vld  = bus.dout_vld;
    o_data = bus.dout_data;
    o_ovf  = bus.dout_ovf;
    o_acc  = bus.din_vld & bus.din_rd;
    o_xfer = bus.dout_vld & bus.dout_rd & ~clr;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] s, input logic rd);
    int k;
    int guard;
    k = 0;
    guard = 0;
    while (k < 4 && guard < 40) begin
      cyc(1'b1, s[4*k +: 4], rd, 1'b0);
      if (o_acc) k++;
      guard++;
    end
    check("feed_accepts", k, 4);
    bus.din_vld = 1'b0;
  endtask

  task automatic get_result(input string name, input logic [3:0] ed, input logic eo);
    int guard;
    guard = 0;
    o_xfer = 1'b0;
    while (!o_xfer && guard < 20) begin
      cyc(1'b0, 4'h0, 1'b1, 1'b0);
      guard++;
    end
    check({name, "_seen"}, o_xfer, 1);
    check({name, "_data"}, o_data, ed);
    check({name, "_ovf"}, o_ovf, eo);
  endtask

  initial begin
    logic [4:0] m;
    int n7;
    int guard;
    int cur_sum;
    int cur_n;
    logic [4:0] exp_q [$];
    logic [4:0] e;

    bus.din_vld  = 1'b1;
    bus.din_data = 4'h5;
    bus.dout_rd  = 1'b0;

    // Reset held with din_vld high
    repeat (2) @(posedge clk);
    #1;
    check("rst_din_rd", bus.din_rd, 0);
    check("rst_dout_vld", bus.dout_vld, 0);
    check("rst_dout_data", bus.dout_data, 0);
    check("rst_dout_ovf", bus.dout_ovf, 0);
    @(negedge clk);
    bus.din_vld = 1'b0;
    rst_n = 1'b1;

    // 1,2,3,4 with latency and single-cycle valid
    feed({4'd4, 4'd3, 4'd2, 4'd1}, 1'b1);
    check("lat_vld_after_last", bus.dout_vld, 1);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    check("lat_xfer", o_xfer, 1);
    check("lat_data", o_data, 10);
    check("lat_ovf", o_ovf, 0);
    check("lat_vld_drop", bus.dout_vld, 0);

    // Table of blocks
    m = model(16); vecs[0] = '{{4'd0, 4'd0, 4'd1, 4'd15}, m[3:0], m[4]};
    m = model(15); vecs[1] = '{{4'd0, 4'd5, 4'd5, 4'd5}, m[3:0], m[4]};
    m = model(32); vecs[2] = '{{4'd8, 4'd8, 4'd8, 4'd8}, m[3:0], m[4]};
    m = model(0);  vecs[3] = '{{4'd0, 4'd0, 4'd0, 4'd0}, m[3:0], m[4]};
    m = model(21); vecs[4] = '{{4'd2, 4'd1, 4'd9, 4'd9}, m[3:0], m[4]};
    m = model(10); vecs[5] = '{{4'd1, 4'd2, 4'd3, 4'd4}, m[3:0], m[4]};
`ifdef ADD_ACC_SATURATE_EN
    check("model_sat_15_1", model(16), 5'h1F);
`else
    check("model_wrap_15_1", model(16), 5'h10);
`endif
    for (int i = 0; i < 6; i++) begin
      feed(vecs[i].s, 1'b1);
      get_result($sformatf("vec%0d", i), vecs[i].exp_d, vecs[i].exp_o);
    end

    // Backpressure: result held, no input accepted
    feed({4'd1, 4'd1, 4'd1, 4'd1}, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 4'd7, 1'b0, 1'b0);
      check("bp_hold_data", o_data, 4);
      check("bp_din_rd", o_drd, 0);
      check("bp_no_accept", o_acc, 0);
    end
    bus.din_vld = 1'b0;
    get_result("bp_first", 4'd4, 1'b0);
    feed({4'd2, 4'd2, 4'd2, 4'd2}, 1'b1);
    get_result("bp_next", 4'd8, 1'b0);

    // clr mid-block blocks a simultaneous sample
    n7 = 0;
    guard = 0;
    while (n7 < 2 && guard < 20) begin
      cyc(1'b1, 4'd7, 1'b1, 1'b0);
      if (o_acc) n7++;
      guard++;
    end
    cyc(1'b1, 4'd9, 1'b1, 1'b1);
    check("clr_din_rd", o_drd, 0);
    check("clr_no_accept", o_acc, 0);
    feed({4'd1, 4'd1, 4'd1, 4'd1}, 1'b1);
    get_result("clr_block", 4'd4, 1'b0);

    // Async reset during EMIT
    feed({4'd1, 4'd1, 4'd1, 4'd1}, 1'b0);
    check("emit_before_rst", bus.dout_vld, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_vld", bus.dout_vld, 0);
    check("rst_async_data", bus.dout_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    feed({4'd0, 4'd0, 4'd0, 4'd3}, 1'b1);
    get_result("post_rst", 4'd3, 1'b0);

    // Randomized traffic against the block-sum model
    cur_sum = 0;
    cur_n = 0;
    for (int c = 0; c < 800; c++) begin
      logic v, r, k;
      logic [3:0] d;
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 9) < 6);
      k = ($urandom_range(0, 49) == 0);
      d = 4'($urandom_range(0, 15));
      cyc(v, d, r, k);
      check("rnd_vld", o_vld, (exp_q.size() != 0));
      check("rnd_din_rd", o_drd, (exp_q.size() == 0) && !k);
      if (k) begin
        cur_sum = 0;
        cur_n = 0;
        exp_q.delete();
      end else begin
        if (o_acc) begin
          cur_sum += d;
          cur_n++;
          if (cur_n == BL) begin
            exp_q.push_back(model(cur_sum));
            cur_sum = 0;
            cur_n = 0;
          end
        end
        if (o_xfer) begin
          if (exp_q.size() == 0) begin
            check("rnd_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("rnd_data", o_data, e[3:0]);
            check("rnd_ovf", o_ovf, e[4]);
          end
        end
      end
    end
    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      cyc(1'b0, 4'h0, 1'b1, 1'b0);
      if (o_xfer) begin
        e = exp_q.pop_front();
        check("drain_data", o_data, e[3:0]);
        check("drain_ovf", o_ovf, e[4]);
      end
      guard++;
    end
    check("drain_done", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
